// File: rtl/trig_beam_scaler.sv
// trig_beam_scaler: per-beam trigger rate scaler in the ifclk domain.
// Each ifclk cycle with a beam's trigger high and unmasked counts as one hit.
// Hits accumulate over GATE_CYCLES cycles. At gate end the counts go into a
// readout bank and the accumulators restart. The bank is read one beam at a
// time through sel_i.
//
// Ports:
//   ifclk     sole clock
//   rst_i     asynchronous active-high reset
//   trig_i    [NBEAMS]      per-beam trigger levels (ifclk synchronous)
//   mask_i    [NBEAMS]      1 = beam ignored
//   enable_i                run enable; low aborts the current gate period
//   sel_i     [SEL_W]       readout beam select
//   count_o   [SCALER_BITS] latched count of the selected beam (registered)
//   sat_o                   selected beam saturated in its latched period
//   update_o                one-cycle pulse after a new bank is latched
//   seq_o     [SEQ_BITS]    bank update count, wrapping

// One beam: saturating accumulator, sticky overflow flag and bank entry.
module trig_beam_lane #(
  parameter int SCALER_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   term,
  input  logic                   hit,
  output logic [SCALER_BITS-1:0] bank,
  output logic                   banksat
);
  logic [SCALER_BITS-1:0] acc;
  logic                   ovf;
  logic                   full;
  logic [SCALER_BITS-1:0] sum;

  assign full = &acc;
  // Stick at all-ones instead of wrapping.
  assign sum  = full ? acc : acc + SCALER_BITS'(hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      bank    <= '0;
      banksat <= 1'b0;
    end else if (!en) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (term) begin
      // The terminal-cycle hit belongs to the period that is ending.
      bank    <= sum;
      banksat <= ovf | (hit & full);
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      acc <= sum;
      ovf <= ovf | (hit & full);
    end
  end
endmodule

module trig_beam_scaler #(
  parameter int NBEAMS      = 2,
  parameter int SCALER_BITS = 16,
  parameter int GATE_CYCLES = 125000,
  parameter int SEQ_BITS    = 8,
  localparam int SEL_W      = $clog2(NBEAMS)
) (
  input  logic                   ifclk,
  input  logic                   rst_i,
  input  logic [NBEAMS-1:0]      trig_i,
  input  logic [NBEAMS-1:0]      mask_i,
  input  logic                   enable_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [SCALER_BITS-1:0] count_o,
  output logic                   sat_o,
  output logic                   update_o,
  output logic [SEQ_BITS-1:0]    seq_o
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SEL_W:0] NB   = (SEL_W + 1)'(NBEAMS);

  logic [GW-1:0]                        gcnt;
  logic                                 term;
  logic [NBEAMS-1:0]                    hit;
  logic [NBEAMS-1:0][SCALER_BITS-1:0]   bank;
  logic [NBEAMS-1:0]                    banksat;

  assign hit  = trig_i & ~mask_i;
  assign term = enable_i && (gcnt == LAST);

  // Gate counter: held at 0 while disabled so the first enabled cycle is 0.
  always_ff @(posedge ifclk or posedge rst_i) begin
    if (rst_i)              gcnt <= '0;
    else if (!enable_i || term) gcnt <= '0;
    else                    gcnt <= gcnt + 1'b1;
  end

  for (genvar i = 0; i < NBEAMS; i++) begin : g_lane
    trig_beam_lane #(.SCALER_BITS(SCALER_BITS)) u_lane (
      .clk     (ifclk),
      .rst     (rst_i),
      .en      (enable_i),
      .term    (term),
      .hit     (hit[i]),
      .bank    (bank[i]),
      .banksat (banksat[i])
    );
  end

  always_ff @(posedge ifclk or posedge rst_i) begin
    if (rst_i) begin
      update_o <= 1'b0;
      seq_o    <= '0;
    end else begin
      update_o <= term;
      seq_o    <= seq_o + SEQ_BITS'(term);
    end
  end

  // Readout mux; out-of-range selects read as zero.
  always_ff @(posedge ifclk or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
      sat_o   <= 1'b0;
    end else if ({1'b0, sel_i} < NB) begin
      count_o <= bank[sel_i];
      sat_o   <= banksat[sel_i];
    end else begin
      count_o <= '0;
      sat_o   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_trig_beam_scaler.sv
module tb_trig_beam_scaler;
  localparam int NB = 3;
  localparam int SB = 3;
  localparam int GC = 10;
  localparam int QB = 2;

  logic          ifclk = 1'b0;
  logic          rst_i;
  logic [NB-1:0] trig_i;
  logic [NB-1:0] mask_i;
  logic          enable_i;
  logic [1:0]    sel_i;
  logic [SB-1:0] count_o;
  logic          sat_o;
  logic          update_o;
  logic [QB-1:0] seq_o;

  int tests = 0;
  int fails = 0;

  trig_beam_scaler #(.NBEAMS(NB), .SCALER_BITS(SB), .GATE_CYCLES(GC), .SEQ_BITS(QB)) dut (
    .ifclk(ifclk), .rst_i(rst_i), .trig_i(trig_i), .mask_i(mask_i),
    .enable_i(enable_i), .sel_i(sel_i), .count_o(count_o), .sat_o(sat_o),
    .update_o(update_o), .seq_o(seq_o)
  );

  always #5 ifclk = ~ifclk;

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [NB-1:0] t, input logic [NB-1:0] m, input logic e);
    trig_i = t; mask_i = m; enable_i = e;
    @(posedge ifclk); #1;
  endtask

  // One enabled gate period starting at gcnt=0. Bit k of a pattern = level at gcnt k.
  task automatic run_period(input logic [9:0] p0, input logic [9:0] p1, input logic [9:0] p2,
                            input logic [9:0] m0, output int upd_mid, output logic upd_end);
    upd_mid = 0;
    for (int k = 0; k < GC; k++) begin
      step({p2[k], p1[k], p0[k]}, {2'b00, m0[k]}, 1'b1);
      if (k < GC - 1 && update_o) upd_mid++;
    end
    upd_end = update_o;
  endtask

  // Disabled clock with sel applied; leaves gcnt at 0 and the bank untouched.
  task automatic read_beam(input logic [1:0] s, output logic [SB-1:0] c, output logic st);
    sel_i = s;
    step('0, '0, 1'b0);
    c = count_o; st = sat_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; trig_i = '0; mask_i = '0; enable_i = 1'b0; sel_i = 2'd0;
    repeat (2) @(posedge ifclk);
    #1;
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if (sat_o !== 1'b0) begin fails++; $display("FAIL reset_sat got %0b exp 0", sat_o); end
    tests++; if (update_o !== 1'b0) begin fails++; $display("FAIL reset_update got %0b exp 0", update_o); end
    tests++; if (seq_o !== 2'd0) begin fails++; $display("FAIL reset_seq got %0d exp 0", seq_o); end
    rst_i = 1'b0;
    step('0, '0, 1'b0);
  endtask

  task automatic test_basic;
    int um; logic ue; logic [SB-1:0] c; logic st;
    run_period(10'b0000001111, 10'b0, 10'b0, 10'b0, um, ue);
    tests++; if (um !== 0 || ue !== 1'b1) begin fails++; $display("FAIL basic_update1 got mid=%0d end=%0b exp mid=0 end=1", um, ue); end
    tests++; if (seq_o !== 2'd1) begin fails++; $display("FAIL basic_seq1 got %0d exp 1", seq_o); end
    run_period(10'b0000001111, 10'b0, 10'b0, 10'b0, um, ue);
    tests++; if (um !== 0 || ue !== 1'b1) begin fails++; $display("FAIL basic_update2 got mid=%0d end=%0b exp mid=0 end=1", um, ue); end
    tests++; if (seq_o !== 2'd2) begin fails++; $display("FAIL basic_seq2 got %0d exp 2", seq_o); end
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd4 || st !== 1'b0) begin fails++; $display("FAIL basic_beam0 got %0d/%0b exp 4/0", c, st); end
    read_beam(2'd1, c, st);
    tests++; if (c !== 3'd0) begin fails++; $display("FAIL basic_beam1 got %0d exp 0", c); end
  endtask

  task automatic test_terminal_hit;
    int um; logic ue; logic [SB-1:0] c; logic st;
    run_period(10'b0, 10'b1000000000, 10'b0, 10'b0, um, ue);
    read_beam(2'd1, c, st);
    tests++; if (c !== 3'd1) begin fails++; $display("FAIL term_hit_beam1 got %0d exp 1", c); end
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd0) begin fails++; $display("FAIL term_hit_beam0 got %0d exp 0", c); end
    run_period(10'b0, 10'b0, 10'b0, 10'b0, um, ue);
    read_beam(2'd1, c, st);
    tests++; if (c !== 3'd0) begin fails++; $display("FAIL term_hit_next got %0d exp 0", c); end
  endtask

  task automatic test_saturate;
    int um; logic ue; logic [SB-1:0] c; logic st;
    // beam0: 10 hits; beam1: exactly 7; beam2: 7 then a terminal-cycle hit.
    run_period(10'b1111111111, 10'b0001111111, 10'b1001111111, 10'b0, um, ue);
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd7 || st !== 1'b1) begin fails++; $display("FAIL sat_beam0 got %0d/%0b exp 7/1", c, st); end
    read_beam(2'd1, c, st);
    tests++; if (c !== 3'd7 || st !== 1'b0) begin fails++; $display("FAIL sat_exact7 got %0d/%0b exp 7/0", c, st); end
    read_beam(2'd2, c, st);
    tests++; if (c !== 3'd7 || st !== 1'b1) begin fails++; $display("FAIL sat_terminal got %0d/%0b exp 7/1", c, st); end
    read_beam(2'd3, c, st);
    tests++; if (c !== 3'd0 || st !== 1'b0) begin fails++; $display("FAIL sel_invalid got %0d/%0b exp 0/0", c, st); end
    run_period(10'b0000011111, 10'b0, 10'b0, 10'b0, um, ue);
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd5 || st !== 1'b0) begin fails++; $display("FAIL sat_clear got %0d/%0b exp 5/0", c, st); end
  endtask

  task automatic test_mask;
    int um; logic ue; logic [SB-1:0] c; logic st;
    run_period(10'b1111111111, 10'b0, 10'b0, 10'b1111111111, um, ue);
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd0) begin fails++; $display("FAIL mask_full got %0d exp 0", c); end
    run_period(10'b1111111111, 10'b0, 10'b0, 10'b0000001111, um, ue);
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd6) begin fails++; $display("FAIL mask_unmask4 got %0d exp 6", c); end
  endtask

  task automatic test_enable_gap;
    int um; logic ue; int gap_upd; int first; logic [SB-1:0] c; logic st;
    sel_i = 2'd0;
    run_period(10'b0000000111, 10'b0, 10'b0, 10'b0, um, ue);
    gap_upd = 0;
    for (int k = 0; k < 5; k++) begin step(3'b001, '0, 1'b1); if (update_o) gap_upd++; end
    for (int k = 0; k < 3; k++) begin step(3'b001, '0, 1'b0); if (update_o) gap_upd++; end
    tests++; if (gap_upd !== 0) begin fails++; $display("FAIL gap_no_update got %0d pulses exp 0", gap_upd); end
    tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL gap_bank_kept got %0d exp 3", count_o); end
    first = -1;
    for (int k = 0; k < 15 && first < 0; k++) begin
      step({2'b00, k < 2}, '0, 1'b1);
      if (update_o) first = k;
    end
    tests++; if (first !== GC - 1) begin fails++; $display("FAIL gap_restart_update got step %0d exp %0d", first, GC - 1); end
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd2) begin fails++; $display("FAIL gap_discard got %0d exp 2", c); end
  endtask

  task automatic test_async_reset;
    int um; logic ue; logic [SB-1:0] c; logic st;
    sel_i = 2'd0;
    for (int k = 0; k < 7; k++) step(3'b001, '0, 1'b1);
    tests++; if (count_o !== 3'd2) begin fails++; $display("FAIL areset_pre got %0d exp 2", count_o); end
    #2 rst_i = 1'b1;
    #1;
    tests++; if (count_o !== 3'd0 || sat_o !== 1'b0 || update_o !== 1'b0 || seq_o !== 2'd0) begin
      fails++; $display("FAIL areset_outputs got c=%0d s=%0b u=%0b q=%0d exp all 0", count_o, sat_o, update_o, seq_o);
    end
    trig_i = '0;
    #2 rst_i = 1'b0;
    run_period(10'b0000000001, 10'b0, 10'b0, 10'b0, um, ue);
    tests++; if (um !== 0 || ue !== 1'b1 || seq_o !== 2'd1) begin
      fails++; $display("FAIL areset_first_update got mid=%0d end=%0b seq=%0d exp 0/1/1", um, ue, seq_o);
    end
    read_beam(2'd0, c, st);
    tests++; if (c !== 3'd1) begin fails++; $display("FAIL areset_acc_cleared got %0d exp 1", c); end
  endtask

  task automatic test_seq_wrap;
    int um; logic ue; logic [QB-1:0] q [4];
    for (int p = 0; p < 4; p++) begin
      run_period(10'b0, 10'b0, 10'b0, 10'b0, um, ue);
      q[p] = seq_o;
    end
    tests++; if (q[0] !== 2'd2 || q[1] !== 2'd3 || q[2] !== 2'd0 || q[3] !== 2'd1) begin
      fails++; $display("FAIL seq_wrap got %0d,%0d,%0d,%0d exp 2,3,0,1", q[0], q[1], q[2], q[3]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_terminal_hit;
    test_saturate;
    test_mask;
    test_enable_gap;
    test_async_reset;
    test_seq_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trig_beam_scaler.md
# trig_beam_scaler

Per-beam trigger rate scaler in the ifclk domain, directly downstream of the aclk→ifclk trigger stretcher. Each ifclk cycle in which a beam's trigger is high counts as one hit. Hits are accumulated over a fixed gate period. At gate end the counts are latched into a readout bank and the accumulators restart. The bank is read one beam at a time through a select port, for threshold servo and housekeeping logic.

## Interface
- NBEAMS, 2: number of beams; must be ≥2.
- SCALER_BITS, 16: width of each accumulator and bank entry.
- GATE_CYCLES, 125000: gate period in ifclk cycles; must be ≥2.
- SEQ_BITS, 8: width of the update sequence counter.

Ports:
- ifclk  in  1  sole clock.
- rst_i  in  1  reset, asynchronous, active-high.
- trig_i  in  NBEAMS  per-beam trigger levels, synchronous to ifclk.
- mask_i  in  NBEAMS  1 = beam ignored, so its hits do not count.
- enable_i  in  1  scaler run enable.
- sel_i  in  $clog2(NBEAMS)  readout beam select.
- count_o  out  SCALER_BITS  latched count of the selected beam.
- sat_o  out  1  selected beam saturated during its latched period.
- update_o  out  1  one-cycle pulse: a new bank has been latched.
- seq_o  out  SEQ_BITS  number of bank updates, modulo 2^SEQ_BITS.

## Operation
- hit[i] = trig_i[i] & ~mask_i[i], evaluated combinationally each cycle.
- Gate counter gcnt runs 0..GATE_CYCLES-1 while enable_i=1.
  - Terminal cycle: gcnt==GATE_CYCLES-1. gcnt wraps to 0 on the next edge.
- Accumulator acc[i] (SCALER_BITS) and sticky flag ovf[i]:
  - Non-terminal cycle: acc[i] <= acc[i]+hit[i], saturating at 2^SCALER_BITS-1. ovf[i] is set if a hit arrives while acc[i] is already all-ones.
  - Terminal cycle: bank[i] <= saturating acc[i]+hit[i], so the terminal-cycle hit belongs to the ending period. banksat[i] <= ovf[i] | (hit & acc all-ones). acc[i] <= 0 and ovf[i] <= 0.
- After every terminal cycle: update_o pulses on the next cycle and seq_o increments (wraps to 0).
- enable_i=0: gcnt, acc and ovf are held at 0 and no update occurs. bank, banksat and seq_o retain their values.
- Deasserting enable_i mid-period aborts the period: partial counts are discarded and there is no update_o.
- The first enabled cycle is gcnt=0 and its hit counts.
- count_o <= bank[sel_i] and sat_o <= banksat[sel_i], registered every cycle.
- sel_i ≥ NBEAMS: count_o=0, sat_o=0.

## Timing
- Reset values: count_o=0, sat_o=0, update_o=0, seq_o=0. All of gcnt, acc, ovf, bank and banksat are 0.
- Reset asserted mid-period clears everything immediately (asynchronous). The first period after reset deasserts starts at gcnt=0, provided enable_i=1.
- A hit at cycle T appears in acc at T+1.
- Terminal cycle T:
  - bank valid at T+1.
  - update_o=1 and seq_o incremented during T+1.
  - count_o shows the new value for the current sel_i from T+2.
- sel_i change at cycle T: count_o and sat_o reflect it at T+1.
- Update period is exactly GATE_CYCLES cycles while enable_i stays high.
- Masking changes take effect on the same cycle as the mask change.
- No handshake: the reader samples count_o on or after the cycle following update_o, and before the next update.

## Test plan
- GATE_CYCLES=10, NBEAMS=2, trig_i[0] high on cycles 0–3 of the period, trig_i[1] low:
  - update_o pulses once every 10 cycles.
  - sel_i=0 gives count_o=4; sel_i=1 gives count_o=0; seq_o increments by 1 per update.
- Hit only on the terminal cycle (gcnt=9) of beam 1: that bank shows count 1, and the following period shows 0 if no further hits.
- SCALER_BITS=3, GATE_CYCLES=12, trig_i[0] held high: count_o=7, sat_o=1. Then drop trig_i[0] to 5 hits per period: count_o=5, sat_o=0.
- mask_i[0]=1 with trig_i[0] held high for a full period: count_o=0 for beam 0. Unmask mid-period at gcnt=4: the next bank shows 6.
- enable_i dropped at gcnt=5 for 3 cycles, then raised:
  - No update_o during the gap.
  - Bank keeps its prior value.
  - The next update_o occurs exactly 10 cycles after the rise.
- rst_i asserted asynchronously at gcnt=7 with acc=7: all outputs go 0 immediately, and after release the first update occurs after 10 enabled cycles with seq_o=1.
- SEQ_BITS=2: after 4 updates seq_o wraps to 0.
